// File: rtl/layer5_argmax_if.sv
// Frame-in / result-out bundle for the layer-5 argmax stage.
// The slave modport is the argmax block's view, the master modport is the
// neuron-side producer / downstream consumer view.
// Optional: ARGMAX_SCORE_EN adds the max_score result field.
interface layer5_argmax_if #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
);
    logic                        in_valid;
    logic                        in_ready;
    logic [32*NUM_CLASSES-1:0]   in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic [IDX_W-1:0]            class_idx;
    logic                        all_zero;
    logic                        nan_seen;
`ifdef ARGMAX_SCORE_EN
    logic [31:0]                 max_score;
`endif

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output class_idx,
        output all_zero,
        output nan_seen
`ifdef ARGMAX_SCORE_EN
        ,
        output max_score
`endif
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  class_idx,
        input  all_zero,
        input  nan_seen
`ifdef ARGMAX_SCORE_EN
        ,
        input  max_score
`endif
    );
endinterface

// File: rtl/layer5_argmax.sv
// layer5_argmax: serial argmax over one frame of NUM_CLASSES single-precision
// ReLU outputs. The frame is captured in one cycle, then scanned one class per
// cycle with a single 31-bit magnitude comparator; the winning index and the
// all-zero / NaN flags are offered through a valid/ready handshake.
// Optional: define ARGMAX_SCORE_EN to expose the sanitized maximum as max_score.
module layer5_argmax #(
    parameter int NUM_CLASSES = 10,
    parameter int IDX_W       = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    layer5_argmax_if.slave     bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (NUM_CLASSES < 1 || NUM_CLASSES > 16) begin : g_bad_num_classes
        $error("layer5_argmax: NUM_CLASSES must be in 1..16");
    end
    if ((1 << IDX_W) < NUM_CLASSES) begin : g_bad_idx_w
        $error("layer5_argmax: IDX_W too narrow for NUM_CLASSES");
    end

    // ------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // A one-class frame is fully judged at capture time, so it skips SCAN.
    localparam bit               SINGLE         = (NUM_CLASSES == 1);
    localparam logic [IDX_W-1:0] LAST_IDX       = IDX_W'(NUM_CLASSES - 1);
    localparam logic [IDX_W-1:0] FIRST_SCAN_IDX = SINGLE ? '0 : IDX_W'(1);

    // ------------------------------------------------------------------
    // Sanitizing helpers
    // Negative values (including -0) and NaNs collapse to +0. For the
    // remaining non-negative floats (denormals and +Inf included) the
    // magnitude order equals the unsigned order of bits [30:0], so the sign
    // bit of the sanitized value is always 0 and is never stored.
    // ------------------------------------------------------------------
    function automatic logic is_nan(input logic [31:0] x);
        return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
    endfunction

    function automatic logic [30:0] san_mag(input logic [31:0] x);
        if (x[31] || is_nan(x)) begin
            return 31'd0;
        end
        return x[30:0];
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t             state_reg,    state_next;
    logic [IDX_W-1:0]   cnt_reg,      cnt_next;
    logic [IDX_W-1:0]   best_idx_reg, best_idx_next;
    logic [30:0]        best_val_reg, best_val_next;
    logic               all_zero_reg, all_zero_next;
    logic               nan_seen_reg, nan_seen_next;
    logic [31:0]        frame_reg [NUM_CLASSES];

    logic               accept;
    logic [31:0]        first_word;
    logic [30:0]        first_mag;
    logic [31:0]        cur_word;
    logic [30:0]        cur_mag;
    logic               cur_nan;

    assign accept     = bus.in_valid && (state_reg == IDLE);
    assign first_word = bus.in_data[31:0];
    assign first_mag  = san_mag(first_word);

    // ------------------------------------------------------------------
    // Frame buffer: every lane is loaded only on the accepting edge, so
    // in_data may change freely while the frame is being scanned.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_CLASSES; gi++) begin : g_lane
        // Capture class gi of the incoming frame on acceptance.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                frame_reg[gi] <= 32'd0;
            end else if (accept) begin
                frame_reg[gi] <= bus.in_data[32*gi +: 32];
            end
        end
    end

    // Select the class currently under scan from the buffer.
    always_comb begin
        cur_word = 32'd0;
        for (int k = 0; k < NUM_CLASSES; k++) begin
            if (cnt_reg == IDX_W'(k)) begin
                cur_word = frame_reg[k];
            end
        end
    end

    assign cur_mag = san_mag(cur_word);
    assign cur_nan = is_nan(cur_word);

    // ------------------------------------------------------------------
    // Next-state and datapath update.
    // Class 0 is judged straight from in_data at capture, so SCAN starts at
    // index 1 and the result is ready NUM_CLASSES-1 edges after acceptance.
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        best_idx_next = best_idx_reg;
        best_val_next = best_val_reg;
        all_zero_next = all_zero_reg;
        nan_seen_next = nan_seen_reg;

        case (state_reg)
            IDLE: begin
                if (accept) begin
                    best_val_next = first_mag;
                    best_idx_next = '0;
                    cnt_next      = FIRST_SCAN_IDX;
                    nan_seen_next = is_nan(first_word);
                    all_zero_next = (first_mag == 31'd0);
                    state_next    = SINGLE ? DONE : SCAN;
                end
            end

            SCAN: begin
                // Strict greater-than keeps the lowest index on ties.
                if (cur_mag > best_val_reg) begin
                    best_val_next = cur_mag;
                    best_idx_next = cnt_reg;
                end
                nan_seen_next = nan_seen_reg | cur_nan;
                if (cur_mag != 31'd0) begin
                    all_zero_next = 1'b0;
                end
                if (cnt_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + IDX_W'(1);
                end
            end

            DONE: begin
                // Result registers are left untouched so they hold until taken.
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State and result registers; reset abandons any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            cnt_reg      <= '0;
            best_idx_reg <= '0;
            best_val_reg <= 31'd0;
            all_zero_reg <= 1'b0;
            nan_seen_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            best_idx_reg <= best_idx_next;
            best_val_reg <= best_val_next;
            all_zero_reg <= all_zero_next;
            nan_seen_reg <= nan_seen_next;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: handshake flags decode straight from the state register;
    // the result fields are the registered scan results.
    // ------------------------------------------------------------------
    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.class_idx = best_idx_reg;
    assign bus.all_zero  = all_zero_reg;
    assign bus.nan_seen  = nan_seen_reg;

`ifdef ARGMAX_SCORE_EN
    // Sanitized values are never negative, so the score's sign bit is 0.
    assign bus.max_score = {1'b0, best_val_reg};
`endif

endmodule
